// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer for a dual-issue E stage: accepts up to two
// mult/div ops per cycle, runs them oldest first and strobes HI/LO once per op.
module muldiv_ctrl #(
   parameter int MUL_LAT = 3
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [1:0]  req_valid,
   input  logic [3:0]  req_op,
   input  logic [63:0] req_a,
   input  logic [63:0] req_b,
   input  logic        flush,
   output logic        stall_out,
   output logic        hilo_we,
   output logic [31:0] hi_wdata,
   output logic [31:0] lo_wdata,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t      state;
   logic [1:0]  pending;
   logic [1:0]  op_q;
   logic [31:0] a_q, b_q, bmag, quo, rem;
   logic [31:0] hi_res, lo_res;
   logic [4:0]  cnt;

   // Candidate slots: fresh requests in IDLE, leftovers from the same issue in DONE.
   logic [1:0]  cand;
   logic        launch, slot, l_signed;
   logic [1:0]  l_op;
   logic [31:0] l_a, l_b, l_amag, l_bmag;

   always_comb begin
      cand     = (state == IDLE) ? req_valid : ((state == DONE) ? pending : 2'b00);
      launch   = (|cand) && !flush;
      slot     = !cand[0];
      l_op     = slot ? req_op[3:2] : req_op[1:0];
      l_a      = slot ? req_a[63:32] : req_a[31:0];
      l_b      = slot ? req_b[63:32] : req_b[31:0];
      l_signed = (l_op == 2'b10);
      l_amag   = (l_signed && l_a[31]) ? (~l_a + 32'd1) : l_a;
      l_bmag   = (l_signed && l_b[31]) ? (~l_b + 32'd1) : l_b;
   end

   // Low 64 bits of a product of sign- or zero-extended operands is the exact result.
   logic [63:0] ext_a, ext_b, prod;
   always_comb begin
      ext_a = op_q[0] ? {32'b0, a_q} : {{32{a_q[31]}}, a_q};
      ext_b = op_q[0] ? {32'b0, b_q} : {{32{b_q[31]}}, b_q};
      prod  = ext_a * ext_b;
   end

   // One restoring step; quo holds the unconsumed dividend bits in its upper end.
   logic [32:0] rem_sh, diff;
   logic        qbit;
   logic [31:0] rem_nx, quo_nx, div_hi, div_lo;
   logic        d_signed;
   always_comb begin
      rem_sh   = {rem, quo[31]};
      diff     = rem_sh - {1'b0, bmag};
      qbit     = !diff[32];
      rem_nx   = qbit ? diff[31:0] : rem_sh[31:0];
      quo_nx   = {quo[30:0], qbit};
      d_signed = (op_q == 2'b10);
      if (b_q == 32'd0) begin
         div_lo = 32'hFFFF_FFFF;
         div_hi = a_q;
      end else begin
         div_lo = (d_signed && (a_q[31] ^ b_q[31])) ? (~quo_nx + 32'd1) : quo_nx;
         div_hi = (d_signed && a_q[31]) ? (~rem_nx + 32'd1) : rem_nx;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         pending <= 2'b00;
         op_q    <= 2'b00;
         a_q     <= '0;
         b_q     <= '0;
         bmag    <= '0;
         quo     <= '0;
         rem     <= '0;
         hi_res  <= '0;
         lo_res  <= '0;
         cnt     <= '0;
      end else if (flush) begin
         state   <= IDLE;
         pending <= 2'b00;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (launch) begin
                  op_q    <= l_op;
                  a_q     <= l_a;
                  b_q     <= l_b;
                  bmag    <= l_bmag;
                  quo     <= l_amag;
                  rem     <= '0;
                  pending <= cand & ~(slot ? 2'b10 : 2'b01);
                  if (l_op[1]) begin
                     state <= DIV;
                     cnt   <= 5'd31;
                  end else begin
                     state <= MUL;
                     cnt   <= 5'(MUL_LAT - 1);
                  end
               end else begin
                  state <= IDLE;
               end
            end
            MUL: begin
               if (cnt == 5'd0) begin
                  hi_res <= prod[63:32];
                  lo_res <= prod[31:0];
                  state  <= DONE;
               end else begin
                  cnt <= cnt - 5'd1;
               end
            end
            DIV: begin
               rem <= rem_nx;
               quo <= quo_nx;
               if (cnt == 5'd0) begin
                  hi_res <= div_hi;
                  lo_res <= div_lo;
                  state  <= DONE;
               end else begin
                  cnt <= cnt - 5'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Reset and flush both silence every strobe in the cycle they are seen.
   always_comb begin
      stall_out = resetn && !flush && ((state == MUL) || (state == DIV) || launch);
      hilo_we   = resetn && !flush && (state == DONE);
      hi_wdata  = hilo_we ? hi_res : 32'd0;
      lo_wdata  = hilo_we ? lo_res : 32'd0;
      busy      = (state != IDLE);
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized + directed bench for muldiv_ctrl, checked every cycle against a
// transaction-level timeline model built from plain integer arithmetic.
module tb_muldiv_ctrl;
   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [1:0]  req_valid = '0;
   logic [3:0]  req_op = '0;
   logic [63:0] req_a = '0, req_b = '0;
   logic        flush = 1'b0;
   logic        stall_out, hilo_we, busy;
   logic [31:0] hi_wdata, lo_wdata;

   muldiv_ctrl #(.MUL_LAT(LAT)) dut (
      .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .flush(flush), .stall_out(stall_out),
      .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0, bad = 0;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   // Reference result as {hi, lo}
   function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: begin p = 64'(sa * sb); return p; end
         2'b01: return {32'b0, a} * {32'b0, b};
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (op == 2'b10) begin
               q = sa / sb;
               r = sa % sb;
               return {r[31:0], q[31:0]};
            end
            return {a % b, a / b};
         end
      endcase
   endfunction

   // Timeline model of one issue group
   bit          m_active = 0;
   int          m_t, m_n, m_abort, m_end;
   int          m_lat[2];
   logic [31:0] m_hi[2], m_lo[2];

   always @(negedge clk) begin
      if (resetn) begin
         int c, w0, w1;
         logic e_stall, e_we, e_busy;
         logic [63:0] e_data;
         c = cyc;
         e_stall = 0; e_we = 0; e_busy = 0; e_data = '0;
         if (m_active) begin
            w0 = m_t + m_lat[0] + 1;
            w1 = (m_n == 2) ? w0 + m_lat[1] + 1 : w0;
            e_stall = (c >= m_t) && (c < m_end) && (c < m_abort);
            e_busy  = (c > m_t) && (c <= m_end) && (c <= m_abort);
            if (c < m_abort && c == w0) begin
               e_we = 1; e_data = {m_hi[0], m_lo[0]};
            end else if (c < m_abort && m_n == 2 && c == w1) begin
               e_we = 1; e_data = {m_hi[1], m_lo[1]};
            end
         end
         chk("stall_out", 64'(stall_out), 64'(e_stall));
         chk("hilo_we", 64'(hilo_we), 64'(e_we));
         chk("busy", 64'(busy), 64'(e_busy));
         chk("hi_lo_wdata", {hi_wdata, lo_wdata}, e_data);
      end
   end

   int          wr_c[$];
   logic [31:0] wr_hi[$], wr_lo[$];
   always @(negedge clk) begin
      if (hilo_we) begin
         wr_c.push_back(cyc);
         wr_hi.push_back(hi_wdata);
         wr_lo.push_back(lo_wdata);
      end
   end

   task automatic clear_wr();
      wr_c.delete(); wr_hi.delete(); wr_lo.delete();
   endtask

   task automatic check_wr(input string name, input int idx, input int exp_c,
                           input logic [31:0] hi, input logic [31:0] lo);
      if (wr_c.size() <= idx) begin
         chk({name, " missing write"}, 64'(wr_c.size()), 64'(idx + 1));
      end else begin
         chk({name, " write cycle"}, 64'(wr_c[idx]), 64'(exp_c));
         chk({name, " hi/lo"}, {wr_hi[idx], wr_lo[idx]}, {hi, lo});
      end
   endtask

   // Drive a request group this cycle and load the model
   task automatic set_req(input logic [1:0] v, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input int abort_off);
      req_valid = v; req_op = op; req_a = a; req_b = b;
      m_t = cyc; m_n = 0;
      for (int i = 0; i < 2; i++) begin
         if (v[i]) begin
            {m_hi[m_n], m_lo[m_n]} = ref_op(op[2*i +: 2], a[32*i +: 32], b[32*i +: 32]);
            m_lat[m_n] = op[2*i+1] ? 32 : LAT;
            m_n++;
         end
      end
      m_end = m_t + m_lat[0] + 1 + ((m_n == 2) ? m_lat[1] + 1 : 0);
      m_abort = (abort_off >= 0) ? m_t + abort_off : (1 << 30);
      m_active = 1;
   endtask

   // Hold the request like a stalled pipeline until it advances or is flushed
   task automatic run_req();
      int stop;
      stop = (m_abort < m_end) ? m_abort : m_end;
      while (cyc < stop) begin
         @(posedge clk); #1;
      end
      if (m_abort <= m_end) flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; req_valid = 2'b00; m_active = 0;
   endtask

   task automatic issue(input logic [1:0] v, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input int abort_off);
      set_req(v, op, a, b, abort_off);
      run_req();
   endtask

   function automatic logic [31:0] rw();
      case ($urandom_range(0, 6))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 100));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int t, ab;
      logic [1:0] v;
      // Model pins against hand-computed results
      chk("model MULT", ref_op(2'b00, 32'hFFFF_FFFF, 32'd2), 64'hFFFF_FFFF_FFFF_FFFE);
      chk("model MULTU", ref_op(2'b01, 32'hFFFF_FFFF, 32'd2), 64'h0000_0001_FFFF_FFFE);
      chk("model DIV -7/2", ref_op(2'b10, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
      chk("model DIVU 5/0", ref_op(2'b11, 32'd5, 32'd0), 64'h0000_0005_FFFF_FFFF);
      chk("model DIV ovf", ref_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
      chk("model DIVU 100/7", ref_op(2'b11, 32'd100, 32'd7), 64'h0000_0002_0000_000E);

      // Reset with requests present: everything quiet
      req_valid = 2'b11; req_op = 4'b1010;
      repeat (2) @(posedge clk);
      #2;
      chk("reset outputs", {stall_out, hilo_we, busy, hi_wdata, lo_wdata}, '0);
      @(posedge clk); #1;
      resetn = 1'b1;

      clear_wr();
      issue(2'b01, 4'b0000, {32'd0, 32'hFFFF_FFFF}, {32'd0, 32'd2}, -1);
      check_wr("MULT", 0, m_t + 4, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      clear_wr();
      issue(2'b01, 4'b0001, {32'd0, 32'hFFFF_FFFF}, {32'd0, 32'd2}, -1);
      check_wr("MULTU", 0, m_t + 4, 32'd1, 32'hFFFF_FFFE);
      clear_wr();
      issue(2'b01, 4'b0010, {32'd0, 32'hFFFF_FFF9}, {32'd0, 32'd2}, -1);
      check_wr("DIV -7/2", 0, m_t + 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      clear_wr();
      issue(2'b11, 4'b1101, {32'd100, 32'd3}, {32'd7, 32'd4}, -1);
      check_wr("dual slot0", 0, m_t + 4, 32'd0, 32'd12);
      check_wr("dual slot1", 1, m_t + 37, 32'd2, 32'd14);
      clear_wr();
      issue(2'b01, 4'b0011, {32'd0, 32'd5}, 64'd0, -1);
      check_wr("DIVU 5/0", 0, m_t + 33, 32'd5, 32'hFFFF_FFFF);
      clear_wr();
      issue(2'b10, 4'b1000, {32'h8000_0000, 32'd0}, {32'hFFFF_FFFF, 32'd0}, -1);
      check_wr("DIV ovf", 0, m_t + 33, 32'd0, 32'h8000_0000);

      // Flush mid-DIV, and flush together with a fresh request
      clear_wr();
      issue(2'b01, 4'b0010, {32'd0, 32'd1000}, {32'd0, 32'd3}, 5);
      repeat (40) @(posedge clk);
      #1;
      chk("flush no write", 64'(wr_c.size()), 64'd0);
      issue(2'b01, 4'b0001, {32'd0, 32'd9}, {32'd0, 32'd9}, 0);
      repeat (6) @(posedge clk);
      #1;
      chk("flush blocks accept", 64'(wr_c.size()), 64'd0);

      // Asynchronous reset mid-DIV, then a fresh MULTU
      set_req(2'b01, 4'b0010, {32'd0, 32'd77}, {32'd0, 32'd5}, -1);
      t = m_t;
      while (cyc < t + 10) begin
         @(posedge clk); #1;
      end
      #1;
      resetn = 1'b0; m_active = 0;
      #1;
      chk("async reset outputs", {stall_out, hilo_we, busy, hi_wdata, lo_wdata}, '0);
      req_op = 4'b0001; req_a = 64'd2; req_b = 64'd2;
      @(posedge clk); #1;
      resetn = 1'b1;
      clear_wr();
      issue(2'b01, 4'b0001, 64'd2, 64'd2, -1);
      check_wr("post-reset MULTU", 0, m_t + LAT + 1, 32'd0, 32'd4);
      chk("post-reset writes", 64'(wr_c.size()), 64'd1);

      // Random groups, occasional flushes
      for (int n = 0; n < 40; n++) begin
         v = 2'($urandom_range(1, 3));
         ab = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, 75)) : -1;
         issue(v, 4'($urandom), {rw(), rw()}, {rw(), rw()}, ab);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      repeat (3) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3, giving multiply busy cycles; legal range 1..8.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid  input  2  bit i: issue slot i holds a HI/LO-writing mult/div in E (slot 0 older).
REQ-005 SHALL have port req_op  input  4  2 bits per slot, [2i+1:2i]: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port req_a  input  64  rs operand per slot, [32i+31:32i].
REQ-007 SHALL have port req_b  input  64  rt operand per slot, [32i+31:32i].
REQ-008 SHALL have port flush  input  1  synchronous abort of all accepted and pending work.
REQ-009 SHALL have port stall_out  output  1  E stage and all older stages hold while high.
REQ-010 SHALL have port hilo_we  output  1  one-cycle write strobe for HI and LO together.
REQ-011 SHALL have port hi_wdata  output  32  HI write value, valid while hilo_we is high.
REQ-012 SHALL have port lo_wdata  output  32  LO write value, valid while hilo_we is high.
REQ-013 SHALL have port busy  output  1  high when the state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, MUL, DIV and DONE, plus a 2-bit pending mask.
REQ-015 In IDLE with |req_valid and no flush: stall_out=1 combinationally; the block latches the lowest-index valid slot's op and operands; pending <= req_valid with that bit cleared; next state MUL or DIV by op.
REQ-016 While state is not IDLE, the block SHALL ignore req_valid, req_op, req_a and req_b and use latched copies only.
REQ-017 MUL SHALL last exactly MUL_LAT cycles (down-counter); the full 64-bit product uses signed operands for MULT and unsigned for MULTU; HI=product[63:32], LO=product[31:0].
REQ-018 DIV SHALL last exactly 32 cycles; the divider is restoring radix-2 on operand magnitudes, one quotient bit per cycle.
REQ-019 Signed DIV: quotient negated when sign(a) differs from sign(b); remainder takes sign(a); LO=quotient, HI=remainder.
REQ-020 Divide by zero (either op) SHALL give LO=32'hFFFF_FFFF and HI=a, in the same 32 cycles.
REQ-021 DIV 0x8000_0000 / 0xFFFF_FFFF SHALL give LO=0x8000_0000 and HI=0.
REQ-022 DONE SHALL last one cycle with hilo_we=1 and the result on hi_wdata/lo_wdata.
REQ-023 From DONE with pending!=0: latch the lowest pending slot from held inputs, clear its bit, go to MUL or DIV; stall_out=1.
REQ-024 From DONE with pending==0: stall_out=0 and go to IDLE, so the pipeline advances in this cycle.
REQ-025 stall_out SHALL be 1 in MUL and DIV, 1 in IDLE only per REQ-015, and 1 in DONE only per REQ-023.
REQ-026 Single op accepted at cycle t: stall_out=1 for t..t+L, where L=MUL_LAT or 32; DONE and write occur at t+L+1.
REQ-027 Dual op: slot 0 result is written first and slot 1 second; HI/LO end with the slot 1 result; stall_out stays high until the second DONE.
REQ-028 flush SHALL have priority over every event: stall_out=0, hilo_we=0 in that cycle; next state IDLE; pending cleared.
REQ-029 flush in IDLE together with a request: the request is not accepted.
REQ-030 hi_wdata and lo_wdata SHALL be 0 whenever hilo_we=0.

Reset
REQ-031 resetn low SHALL immediately force IDLE, pending=0, counters=0, and stall_out=busy=hilo_we=0, hi_wdata=lo_wdata=0, regardless of state, including mid-DIV.
REQ-032 The first request SHALL be accepted at the first clk edge after resetn deasserts with req_valid high.

Verification
REQ-033 MULT a=0xFFFF_FFFF, b=2, slot 0, MUL_LAT=3 -> stall_out high 4 cycles; at t+4 hilo_we=1, HI=0xFFFF_FFFF, LO=0xFFFF_FFFE; MULTU with the same operands -> HI=1, LO=0xFFFF_FFFE.
REQ-034 DIV a=-7, b=2 -> stall_out high 33 cycles; at t+33 LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
REQ-035 Slot 0 MULTU 3*4 and slot 1 DIVU 100/7 in the same cycle, MUL_LAT=3 -> write HI=0, LO=12 at t+4; write HI=2, LO=14 at t+37; stall_out low only at t+37.
REQ-036 DIVU 5/0 -> LO=0xFFFF_FFFF, HI=5 after 33 cycles.
REQ-037 flush at t+5 of a DIV -> stall_out=0 and no write in that cycle; busy=0 from t+6; no later write occurs.
REQ-038 resetn pulsed low at t+10 of a DIV -> all outputs 0 asynchronously; after release, a new MULTU 2*2 gives LO=4 at its accept cycle +MUL_LAT+1.
